router_pkt_tx: RTL and testbench

Upstream packet source for the 1-to-3 router input port. It accepts a descriptor (destination, length) and a payload byte stream, and serialises them into router packets on packet_valid/data:
- header byte {len[5:0], addr[1:0]}
- len payload bytes
- parity byte (XOR of header and all payload bytes)

Every byte honours router busy back-pressure. It also captures the router err response for each packet and reports per-packet completion.

---
 rtl/router_pkg.sv | 36 +++
 rtl/router_pkt_tx_if.sv | 35 +++
 rtl/router_parity_acc.sv | 27 ++
 rtl/router_pkt_tx.sv | 188 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
package router_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned BYTE_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    CHECK   = 3'd4,
    GAP     = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              bad_parity;
  } desc_t;

  // Router header byte: length in the upper six bits, destination in the lower two.
  function automatic logic [BYTE_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                    input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic desc_bad(input logic [ADDR_W-1:0] addr,
                                    input logic [LEN_W-1:0]  len);
    return (addr == ADDR_INVALID) || (len == '0);
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Descriptor, payload and router-side signals of the packet transmitter.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_bad_parity;
  logic              pl_valid;
  logic              pl_ready;
  logic [BYTE_W-1:0] pl_data;
  logic              busy;
  logic              err;
  logic              packet_valid;
  logic [BYTE_W-1:0] data;
  logic              done;
  logic              done_err;
  logic              desc_reject;

  modport master (
    input  desc_valid, desc_addr, desc_len, desc_bad_parity,
    input  pl_valid, pl_data, busy, err,
    output desc_ready, pl_ready, packet_valid, data,
    output done, done_err, desc_reject
  );

  modport slave (
    output desc_valid, desc_addr, desc_len, desc_bad_parity,
    output pl_valid, pl_data, busy, err,
    input  desc_ready, pl_ready, packet_valid, data,
    input  done, done_err, desc_reject
  );

endinterface

// File: rtl/router_parity_acc.sv
// Running 8-bit XOR accumulator; clear beats seed beats accumulate.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              seed_en,
  input  logic [BYTE_W-1:0] seed,
  input  logic              en,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] acc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (seed_en) begin
      acc <= seed;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Serialises descriptor + payload into router packets (header, payload, parity),
// honouring busy back-pressure and reporting the router err response per packet.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned ERR_WINDOW = 4
) (
  input  logic            clock,
  input  logic            reset,
  router_pkt_tx_if.master bus
);

  localparam int unsigned IDLE_MAX = (ERR_WINDOW > GAP_CYCLES) ? ERR_WINDOW : GAP_CYCLES;
  localparam int unsigned CNT_W    = $clog2(IDLE_MAX + 1) + 1;

  state_t state, state_nx;

  logic [BYTE_W-1:0] data_q, data_d;
  logic              pv_q, pv_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              rej_q, rej_d;
  logic              bad_par_q, bad_par_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d, idle_inc;
  logic              err_q, err_d;

  logic              desc_ready_c;
  logic              pl_ready_c;
  logic              accept_c;
  logic              bad_c;
  logic              win_done_c;
  logic              gap_done_c;
  desc_t             desc_in;

  logic              par_clear, par_seed, par_en;
  logic [BYTE_W-1:0] par_acc;

  assign desc_in = '{addr: bus.desc_addr, len: bus.desc_len, bad_parity: bus.desc_bad_parity};

  assign desc_ready_c = (state == IDLE) && !bus.busy && !reset;
  assign pl_ready_c   = ((state == HEADER) || (state == PAYLOAD)) && !bus.busy && (cnt_q != '0);
  assign accept_c     = bus.desc_valid && desc_ready_c;
  assign bad_c        = desc_bad(desc_in.addr, desc_in.len);

  // One idle counter covers both the err window and the inter-packet gap.
  assign idle_inc   = (32'(idle_q) >= IDLE_MAX) ? idle_q : idle_q + CNT_W'(1);
  assign win_done_c = (idle_q == CNT_W'(ERR_WINDOW - 1));
  assign gap_done_c = (32'(idle_q) + 32'd1) >= 32'(GAP_CYCLES);

  router_parity_acc u_parity (
    .clock   (clock),
    .reset   (reset),
    .clear   (par_clear),
    .seed_en (par_seed),
    .seed    (pack_header(desc_in.len, desc_in.addr)),
    .en      (par_en),
    .din     (bus.pl_data),
    .acc     (par_acc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c && !bad_c) state_nx = HEADER;
      HEADER:  if (!bus.busy) state_nx = PAYLOAD;
      PAYLOAD: if (!bus.busy && (cnt_q == '0)) state_nx = PARITY;
      PARITY:  if (!bus.busy) state_nx = CHECK;
      CHECK:   if (win_done_c) state_nx = GAP;
      GAP:     if (gap_done_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    data_d     = data_q;
    pv_d       = pv_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    rej_d      = 1'b0;
    bad_par_d  = bad_par_q;
    cnt_d      = cnt_q;
    idle_d     = idle_q;
    err_d      = err_q;
    par_clear  = 1'b0;
    par_seed   = 1'b0;
    par_en     = 1'b0;
    case (state)
      IDLE: begin
        data_d = '0;
        pv_d   = 1'b0;
        if (accept_c) begin
          if (bad_c) begin
            rej_d = 1'b1;
          end else begin
            bad_par_d = desc_in.bad_parity;
            cnt_d     = desc_in.len;
            data_d    = pack_header(desc_in.len, desc_in.addr);
            pv_d      = 1'b1;
            par_seed  = 1'b1;
          end
        end
      end
      HEADER, PAYLOAD: begin
        // The next byte loads on the same edge that consumes the current one.
        if (!bus.busy) begin
          if (cnt_q == '0) begin
            data_d = par_acc ^ {BYTE_W{bad_par_q}};
            pv_d   = 1'b0;
          end else if (bus.pl_valid) begin
            data_d = bus.pl_data;
            pv_d   = 1'b1;
            cnt_d  = cnt_q - LEN_W'(1);
            par_en = 1'b1;
          end else begin
            pv_d = 1'b0;
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          data_d = '0;
          idle_d = '0;
          err_d  = 1'b0;
        end
      end
      CHECK: begin
        err_d  = err_q | bus.err;
        idle_d = idle_inc;
        if (win_done_c) begin
          done_d     = 1'b1;
          done_err_d = err_q | bus.err;
        end
      end
      GAP: begin
        idle_d = idle_inc;
        if (gap_done_c) par_clear = 1'b1;
      end
      default: begin
        data_d = '0;
        pv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      pv_q       <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      rej_q      <= 1'b0;
      bad_par_q  <= 1'b0;
      cnt_q      <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      data_q     <= data_d;
      pv_q       <= pv_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      rej_q      <= rej_d;
      bad_par_q  <= bad_par_d;
      cnt_q      <= cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  assign bus.desc_ready   = desc_ready_c;
  assign bus.pl_ready     = pl_ready_c;
  assign bus.packet_valid = pv_q;
  assign bus.data         = data_q;
  assign bus.done         = done_q;
  assign bus.done_err     = done_err_q;
  assign bus.desc_reject  = rej_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: per-cycle trace compared against hand-derived packets.
module tb_router_pkt_tx;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.GAP_CYCLES(2), .ERR_WINDOW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] pl_q [$];
  logic       pv_log   [0:31];
  logic [7:0] data_log [0:31];
  logic       done_log [0:31];
  logic       derr_log [0:31];
  logic       rej_log  [0:31];
  logic       drdy_log [0:31];

  // Cycle i: drive inputs, sample outputs at negedge, advance one rising edge.
  task automatic run_packet(input logic [1:0] a, input logic [5:0] l, input logic bp,
                            input logic [31:0] busy_m, input logic [31:0] stall_m,
                            input logic [31:0] err_m, input int n);
    logic fire;
    for (int i = 0; i < n; i++) begin
      bus.desc_valid      = (i == 0);
      bus.desc_addr       = a;
      bus.desc_len        = l;
      bus.desc_bad_parity = bp;
      bus.busy            = busy_m[i];
      bus.err             = err_m[i];
      bus.pl_valid        = (pl_q.size() != 0) && !stall_m[i];
      bus.pl_data         = (pl_q.size() != 0) ? pl_q[0] : 8'h00;
      @(negedge clock);
      pv_log[i]   = bus.packet_valid;
      data_log[i] = bus.data;
      done_log[i] = bus.done;
      derr_log[i] = bus.done_err;
      rej_log[i]  = bus.desc_reject;
      drdy_log[i] = bus.desc_ready;
      fire        = bus.pl_valid && bus.pl_ready;
      @(posedge clock);
      #1;
      if (fire) void'(pl_q.pop_front());
    end
    bus.desc_valid = 1'b0;
    bus.busy       = 1'b0;
    bus.err        = 1'b0;
    bus.pl_valid   = 1'b0;
    bus.pl_data    = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.desc_valid = 1'b0; bus.desc_addr = 2'd0; bus.desc_len = 6'd0; bus.desc_bad_parity = 1'b0;
    bus.pl_valid = 1'b0; bus.pl_data = 8'h00; bus.busy = 1'b0; bus.err = 1'b0;
    #2;
    checks++;
    if ({bus.packet_valid, bus.data, bus.done, bus.done_err, bus.desc_reject, bus.desc_ready, bus.pl_ready} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pv=%b data=%h done=%b derr=%b rej=%b drdy=%b plrdy=%b want all 0",
               bus.packet_valid, bus.data, bus.done, bus.done_err, bus.desc_reject, bus.desc_ready, bus.pl_ready);
    end
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_ready: got %b want 1", bus.desc_ready);
    end
    @(posedge clock); #1;
  endtask

  // addr=1 len=3, no back-pressure; err pulses only outside the window.
  task automatic test_basic();
    logic [7:0] ed [0:11];
    logic       ep [0:11];
    ed = '{8'h00, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ep = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 32'h0, 32'h0, (32'd1 << 5) | (32'd1 << 10), 14);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (pv_log[i] !== ep[i] || data_log[i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_byte[%0d]: got pv=%b data=%h want pv=%b data=%h", i, pv_log[i], data_log[i], ep[i], ed[i]);
      end
      checks++;
      if (done_log[i] !== (i == 10)) begin
        errors++;
        $display("FAIL basic_done[%0d]: got %b want %b", i, done_log[i], (i == 10));
      end
    end
    checks++;
    if (derr_log[10] !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_err: got %b want 0", derr_log[10]);
    end
    checks++;
    if (drdy_log[0] !== 1'b1 || drdy_log[2] !== 1'b0) begin
      errors++;
      $display("FAIL basic_desc_ready: got idle=%b busy_pkt=%b want 1 0", drdy_log[0], drdy_log[2]);
    end
  endtask

  // Busy for two cycles right after the header; err in the last window cycle.
  task automatic test_busy();
    logic [7:0] ed [0:13];
    logic       ep [0:13];
    ed = '{8'h00, 8'h0D, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ep = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 32'h0000_000C, 32'h0, 32'd1 << 11, 16);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (pv_log[i] !== ep[i] || data_log[i] !== ed[i]) begin
        errors++;
        $display("FAIL busy_byte[%0d]: got pv=%b data=%h want pv=%b data=%h", i, pv_log[i], data_log[i], ep[i], ed[i]);
      end
    end
    checks++;
    if (done_log[11] !== 1'b0 || done_log[12] !== 1'b1 || done_log[13] !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: got %b%b%b want 010", done_log[11], done_log[12], done_log[13]);
    end
    checks++;
    if (derr_log[12] !== 1'b1) begin
      errors++;
      $display("FAIL busy_done_err_edge: got %b want 1", derr_log[12]);
    end
  endtask

  // pl_valid low for three cycles after the first payload byte.
  task automatic test_pl_stall();
    logic [7:0] ed [0:12];
    logic       ep [0:12];
    ed = '{8'h00, 8'h0D, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    ep = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 32'h0, 32'h0000_001C, 32'h0, 16);
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (pv_log[i] !== ep[i] || data_log[i] !== ed[i]) begin
        errors++;
        $display("FAIL stall_byte[%0d]: got pv=%b data=%h want pv=%b data=%h", i, pv_log[i], data_log[i], ep[i], ed[i]);
      end
    end
    checks++;
    if (done_log[13] !== 1'b1 || derr_log[13] !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: got done=%b derr=%b want 1 0", done_log[13], derr_log[13]);
    end
  endtask

  // addr=2 len=1 payload A5: header 06, parity 06^A5=A3 inverted to 5C; err inside window.
  task automatic test_bad_parity();
    logic [7:0] ed [0:8];
    logic       ep [0:8];
    ed = '{8'h00, 8'h06, 8'hA5, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    ep = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    pl_q = '{8'hA5};
    run_packet(2'd2, 6'd1, 1'b1, 32'h0, 32'h0, 32'd1 << 5, 12);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (pv_log[i] !== ep[i] || data_log[i] !== ed[i]) begin
        errors++;
        $display("FAIL badpar_byte[%0d]: got pv=%b data=%h want pv=%b data=%h", i, pv_log[i], data_log[i], ep[i], ed[i]);
      end
    end
    checks++;
    if (done_log[7] !== 1'b0 || done_log[8] !== 1'b1 || derr_log[8] !== 1'b1) begin
      errors++;
      $display("FAIL badpar_done: got pre=%b done=%b derr=%b want 0 1 1", done_log[7], done_log[8], derr_log[8]);
    end
  endtask

  // Invalid descriptors are rejected; a descriptor offered under busy is not taken.
  task automatic test_reject();
    logic [1:0] ra [0:1];
    logic [5:0] rl [0:1];
    ra = '{2'd3, 2'd0};
    rl = '{6'd5, 6'd0};
    for (int t = 0; t < 2; t++) begin
      run_packet(ra[t], rl[t], 1'b0, 32'h0, 32'h0, 32'h0, 4);
      checks++;
      if (rej_log[0] !== 1'b0 || rej_log[1] !== 1'b1 || rej_log[2] !== 1'b0) begin
        errors++;
        $display("FAIL reject_pulse[%0d]: got %b%b%b want 010", t, rej_log[0], rej_log[1], rej_log[2]);
      end
      checks++;
      if (pv_log[1] !== 1'b0 || pv_log[2] !== 1'b0 || pv_log[3] !== 1'b0) begin
        errors++;
        $display("FAIL reject_pv[%0d]: got %b%b%b want 000", t, pv_log[1], pv_log[2], pv_log[3]);
      end
      checks++;
      if (drdy_log[2] !== 1'b1) begin
        errors++;
        $display("FAIL reject_idle[%0d]: got desc_ready=%b want 1", t, drdy_log[2]);
      end
    end
    run_packet(2'd1, 6'd3, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 3);
    checks++;
    if (drdy_log[0] !== 1'b0 || pv_log[1] !== 1'b0 || pv_log[2] !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_accept: got drdy=%b pv=%b%b want 0 00", drdy_log[0], pv_log[1], pv_log[2]);
    end
  endtask

  // Reset in PAYLOAD drops outputs at once; the next packet starts cleanly.
  task automatic test_reset_mid_packet();
    logic [7:0] ed [0:4];
    logic       ep [0:4];
    pl_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 6'd3, 1'b0, 32'h0, 32'h0, 32'h0, 3);
    checks++;
    if (bus.packet_valid !== 1'b1 || bus.data !== 8'h22) begin
      errors++;
      $display("FAIL midpkt_before_reset: got pv=%b data=%h want 1 22", bus.packet_valid, bus.data);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.packet_valid !== 1'b0 || bus.data !== 8'h00 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midpkt_async_reset: got pv=%b data=%h done=%b want 0 00 0", bus.packet_valid, bus.data, bus.done);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    pl_q.delete();
    pl_q = '{8'h01, 8'h02};
    ed = '{8'h00, 8'h08, 8'h01, 8'h02, 8'h0B};
    ep = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    run_packet(2'd0, 6'd2, 1'b0, 32'h0, 32'h0, 32'h0, 12);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pv_log[i] !== ep[i] || data_log[i] !== ed[i]) begin
        errors++;
        $display("FAIL postreset_byte[%0d]: got pv=%b data=%h want pv=%b data=%h", i, pv_log[i], data_log[i], ep[i], ed[i]);
      end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (done_log[i] !== (i == 9)) begin
        errors++;
        $display("FAIL postreset_done[%0d]: got %b want %b", i, done_log[i], (i == 9));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_busy();
    test_pl_stall();
    test_bad_parity();
    test_reject();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
